// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage of the bf8b 8-bit core.
// Accepts a decoded instruction, holds it back while any source register has
// a write still in flight (16-entry pending scoreboard), then latches the
// source operands, op and dst for execute.
// Optional feature macro: OPFETCH_BYPASS_EN enables a writeback-to-fetch
// bypass so a waiting operand can be taken straight from wb_val.
module operand_fetch (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [3:0]   op,
  input  logic [3:0]   src_a,
  input  logic [3:0]   src_b,
  input  logic [3:0]   dst,
  input  logic [127:0] regs,
  input  logic         wb_valid,
  input  logic [3:0]   wb_addr,
  input  logic [7:0]   wb_val,
  output logic [7:0]   opnd_a,
  output logic [7:0]   opnd_b,
  output logic [3:0]   op_out,
  output logic [3:0]   dst_out,
  output logic         stall,
  output logic         ready
);

  localparam logic [3:0] OP_LOD  = 4'b0001;
  localparam logic [3:0] OP_STR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LODI = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q,   state_d;
  logic        was_en_q,  was_en_d;
  logic [15:0] pending_q, pending_d;
  logic [7:0]  opnd_a_q,  opnd_a_d;
  logic [7:0]  opnd_b_q,  opnd_b_d;
  logic [3:0]  op_out_q,  op_out_d;
  logic [3:0]  dst_out_q, dst_out_d;
  logic        stall_q,   stall_d;
  logic        ready_q,   ready_d;

  logic       rd_a, rd_b;
  logic       fwd_a, fwd_b;
  logic       hazard;
  logic       go_done;
  logic [7:0] val_a, val_b;

  function automatic logic reads_a_f(input logic [3:0] o);
    return o inside {OP_LOD, OP_STR, OP_ADD, OP_ADDI, OP_NAND};
  endfunction

  function automatic logic reads_b_f(input logic [3:0] o);
    return o inside {OP_STR, OP_ADD, OP_NAND};
  endfunction

  function automatic logic writes_f(input logic [3:0] o);
    return o inside {OP_LOD, OP_ADD, OP_ADDI, OP_LODI, OP_NAND};
  endfunction

  // Hazard detection, operand selection, FSM next state and scoreboard update.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    was_en_d  = en;
    pending_d = pending_q;
    opnd_a_d  = opnd_a_q;
    opnd_b_d  = opnd_b_q;
    op_out_d  = op_out_q;
    dst_out_d = dst_out_q;
    stall_d   = stall_q;
    ready_d   = ready_q;
    go_done   = 1'b0;

    rd_a = reads_a_f(op);
    rd_b = reads_b_f(op);

    // A pending source being written back on this very edge counts as
    // resolved only when the bypass is built in.
    fwd_a = BYPASS && wb_valid && (wb_addr == src_a) && pending_q[src_a];
    fwd_b = BYPASS && wb_valid && (wb_addr == src_b) && pending_q[src_b];

    hazard = (rd_a && pending_q[src_a] && !fwd_a) ||
             (rd_b && pending_q[src_b] && !fwd_b);

    val_a = 8'h00;
    if (rd_a) val_a = fwd_a ? wb_val : regs[{src_a, 3'b000} +: 8];
    val_b = 8'h00;
    if (rd_b) val_b = fwd_b ? wb_val : regs[{src_b, 3'b000} +: 8];

    // Writeback retires a pending entry; a same-edge set below overrides it.
    if (wb_valid) pending_d[wb_addr] = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en && was_en_q) begin
          if (hazard) begin
            stall_d = 1'b1;
            state_d = WAIT;
          end else begin
            go_done = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!en) begin
          // Upstream withdrew the request: drop it without touching the
          // scoreboard or the previously latched operands.
          stall_d = 1'b0;
          ready_d = 1'b0;
          state_d = IDLE;
        end else if (!hazard) begin
          go_done = 1'b1;
        end
      end
      DONE: begin
        if (!en) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_done) begin
      opnd_a_d  = val_a;
      opnd_b_d  = val_b;
      op_out_d  = op;
      dst_out_d = dst;
      stall_d   = 1'b0;
      ready_d   = 1'b1;
      state_d   = DONE;
      if (writes_f(op)) pending_d[dst] = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge.
    if (rst) begin
      state_q   <= IDLE;
      was_en_q  <= 1'b0;
      pending_q <= 16'h0000;
      opnd_a_q  <= 8'h00;
      opnd_b_q  <= 8'h00;
      op_out_q  <= 4'h0;
      dst_out_q <= 4'h0;
      stall_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      was_en_q  <= was_en_d;
      pending_q <= pending_d;
      opnd_a_q  <= opnd_a_d;
      opnd_b_q  <= opnd_b_d;
      op_out_q  <= op_out_d;
      dst_out_q <= dst_out_d;
      stall_q   <= stall_d;
      ready_q   <= ready_d;
    end
  end

  assign opnd_a  = opnd_a_q;
  assign opnd_b  = opnd_b_q;
  assign op_out  = op_out_q;
  assign dst_out = dst_out_q;
  assign stall   = stall_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: self-checking bench for operand_fetch.
// Transactions are driven one at a time; the expected outcome of each edge
// comes from a transaction-level model: a set of pending registers, a copy
// of the register file and the rule "a source is usable once its pending bit
// is clear (or, with OPFETCH_BYPASS_EN, once it is written back this edge)".
module tb_operand_fetch;

  localparam logic [3:0] OP_LOD  = 4'b0001;
  localparam logic [3:0] OP_STR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LODI = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [3:0]   op, src_a, src_b, dst;
  logic [127:0] regs;
  logic         wb_valid;
  logic [3:0]   wb_addr;
  logic [7:0]   wb_val;
  logic [7:0]   opnd_a, opnd_b;
  logic [3:0]   op_out, dst_out;
  logic         stall, ready;

  operand_fetch dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .src_a(src_a), .src_b(src_b),
    .dst(dst), .regs(regs), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_val(wb_val), .opnd_a(opnd_a), .opnd_b(opnd_b), .op_out(op_out),
    .dst_out(dst_out), .stall(stall), .ready(ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [7:0]  m_regs [16];
  logic [15:0] m_pend;
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_op, m_dst;

  // Per-transaction directives and results
  int          sched_k = -1;
  logic [3:0]  sched_a;
  logic [7:0]  sched_v;
  int          abort_k = -1;
  int          rst_k   = -1;
  int          wb_pct  = 0;
  int          k_ready;
  bit          got_abort;
  bit          stalled_at_accept;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit rd_a_m(input logic [3:0] o);
    return o inside {OP_LOD, OP_STR, OP_ADD, OP_ADDI, OP_NAND};
  endfunction

  function automatic bit rd_b_m(input logic [3:0] o);
    return o inside {OP_STR, OP_ADD, OP_NAND};
  endfunction

  function automatic bit wr_m(input logic [3:0] o);
    return o inside {OP_LOD, OP_ADD, OP_ADDI, OP_LODI, OP_NAND};
  endfunction

  function automatic logic [127:0] pack_regs();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = m_regs[i];
    return r;
  endfunction

  task automatic check_outs(input string tag, input bit exp_ready, input bit exp_stall);
    check({tag, "_ready"}, 32'(ready), 32'(exp_ready));
    check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    check({tag, "_opnd_a"}, 32'(opnd_a), 32'(m_a));
    check({tag, "_opnd_b"}, 32'(opnd_b), 32'(m_b));
    check({tag, "_op_out"}, 32'(op_out), 32'(m_op));
    check({tag, "_dst_out"}, 32'(dst_out), 32'(m_dst));
  endtask

  // Choose the writeback (if any) that happens on the coming edge.
  task automatic drive_wb(input int k, input bit has_hint, input logic [3:0] hint);
    wb_valid = 1'b0;
    wb_addr  = 4'($urandom);
    wb_val   = 8'($urandom);
    if (sched_k >= 0 && k == sched_k) begin
      wb_valid = 1'b1;
      wb_addr  = sched_a;
      wb_val   = sched_v;
    end else if (int'($urandom_range(99)) < wb_pct) begin
      wb_valid = 1'b1;
      if (has_hint && $urandom_range(1) == 1) wb_addr = hint;
      else if (m_pend != 16'h0 && $urandom_range(3) != 0) begin
        for (int t = 0; t < 64 && !m_pend[wb_addr]; t++) wb_addr = 4'($urandom);
      end
    end
  endtask

  // One clock edge; afterwards apply writeback / scoreboard effects to the model.
  task automatic tick(input bit set_en, input logic [3:0] set_a);
    @(posedge clk);
    #1;
    if (!rst) begin
      if (wb_valid) m_pend[wb_addr] = 1'b0;
      if (set_en)   m_pend[set_a]   = 1'b1;
    end
    if (wb_valid) m_regs[wb_addr] = wb_val;
    regs     = pack_regs();
    wb_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [3:0] t_op, input logic [3:0] t_sa,
                         input logic [3:0] t_sb, input logic [3:0] t_d,
                         input int hold);
    bit ra, rb, fa, fb, ok_a, ok_b;
    logic [3:0] hint;
    k_ready = -1;
    got_abort = 1'b0;
    stalled_at_accept = 1'b0;
    op = t_op; src_a = t_sa; src_b = t_sb; dst = t_d;
    ra = rd_a_m(t_op);
    rb = rd_b_m(t_op);

    en = 1'b0;
    drive_wb(-10, 1'b0, 4'h0);
    tick(1'b0, 4'h0);
    check_outs("gap", 1'b0, 1'b0);

    en = 1'b1;
    drive_wb(-10, 1'b0, 4'h0);
    tick(1'b0, 4'h0);
    check_outs("first_edge", 1'b0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      if (k > 0 && k == rst_k) begin
        rst = 1'b1;
        drive_wb(k, 1'b0, 4'h0);
        tick(1'b0, 4'h0);
        rst = 1'b0;
        m_pend = 16'h0; m_a = 8'h0; m_b = 8'h0; m_op = 4'h0; m_dst = 4'h0;
        check_outs("rst_wait", 1'b0, 1'b0);
        return;
      end
      if (k > 0 && k == abort_k) begin
        en = 1'b0;
        drive_wb(k, 1'b0, 4'h0);
        tick(1'b0, 4'h0);
        got_abort = 1'b1;
        check_outs("abort", 1'b0, 1'b0);
        return;
      end
      hint = (ra && m_pend[t_sa]) ? t_sa : t_sb;
      drive_wb(k, 1'b1, hint);
      fa = BYP && wb_valid && wb_addr == t_sa && m_pend[t_sa];
      fb = BYP && wb_valid && wb_addr == t_sb && m_pend[t_sb];
      ok_a = !ra || !m_pend[t_sa] || fa;
      ok_b = !rb || !m_pend[t_sb] || fb;
      if (ok_a && ok_b) begin
        m_a   = !ra ? 8'h00 : (fa ? wb_val : m_regs[t_sa]);
        m_b   = !rb ? 8'h00 : (fb ? wb_val : m_regs[t_sb]);
        m_op  = t_op;
        m_dst = t_d;
        tick(wr_m(t_op), t_d);
        k_ready = k;
        check_outs("accept", 1'b1, 1'b0);
        break;
      end
      if (k == 0) stalled_at_accept = 1'b1;
      tick(1'b0, 4'h0);
      check_outs("wait", 1'b0, 1'b1);
    end

    if (k_ready < 0) begin
      check("timeout", 32'd0, 32'd1);
      en = 1'b0;
      tick(1'b0, 4'h0);
      return;
    end

    for (int h = 0; h < hold; h++) begin
      drive_wb(-10, 1'b0, 4'h0);
      tick(1'b0, 4'h0);
      check_outs("hold", 1'b1, 1'b0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r_op;
    rst = 1'b1; en = 1'b0; op = 4'h0; src_a = 4'h0; src_b = 4'h0; dst = 4'h0;
    wb_valid = 1'b0; wb_addr = 4'h0; wb_val = 8'h0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'($urandom);
    m_regs[1] = 8'h05;
    m_regs[2] = 8'h07;
    regs = pack_regs();
    m_pend = 16'h0; m_a = 8'h0; m_b = 8'h0; m_op = 4'h0; m_dst = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_outs("reset", 1'b0, 1'b0);
    rst = 1'b0;

    // ADD r1,r2 -> r3: two-edge latency, no stall
    run_txn(OP_ADD, 4'd1, 4'd2, 4'd3, 1);
    check("add_latency", 32'(k_ready), 32'd0);
    check("add_opnd_a", 32'(opnd_a), 32'h05);
    check("add_opnd_b", 32'(opnd_b), 32'h07);

    // ADDI r3: waits for writeback of r3 = 0C
    sched_k = 2; sched_a = 4'd3; sched_v = 8'h0C;
    run_txn(OP_ADDI, 4'd3, 4'd0, 4'd6, 1);
    sched_k = -1;
    check("addi_stalled", 32'(stalled_at_accept), 32'd1);
    check("addi_latency", 32'(k_ready), BYP ? 32'd2 : 32'd3);
    check("addi_opnd_a", 32'(opnd_a), 32'h0C);

    // LODI r4 twice; writeback of r4 on the second DONE-entry edge loses to the set
    run_txn(OP_LODI, 4'd0, 4'd0, 4'd4, 0);
    sched_k = 0; sched_a = 4'd4; sched_v = 8'h44;
    run_txn(OP_LODI, 4'd0, 4'd0, 4'd4, 0);
    sched_k = 3; sched_a = 4'd4; sched_v = 8'h33;
    run_txn(OP_ADDI, 4'd4, 4'd0, 4'd7, 0);
    sched_k = -1;
    check("set_wins_stall", 32'(stalled_at_accept), 32'd1);
    check("set_wins_opnd", 32'(opnd_a), 32'h33);

    // NAND r5,r5 with r5 pending; request withdrawn after two stall cycles
    run_txn(OP_LODI, 4'd0, 4'd0, 4'd5, 0);
    abort_k = 2;
    run_txn(OP_NAND, 4'd5, 4'd5, 4'd8, 0);
    abort_k = -1;
    check("nand_aborted", 32'(got_abort), 32'd1);

    // LOD r5 still stalls (scoreboard kept); reset during its wait
    rst_k = 1;
    run_txn(OP_LOD, 4'd5, 4'd0, 4'd9, 0);
    rst_k = -1;
    check("lod5_pending_kept", 32'(stalled_at_accept), 32'd1);
    run_txn(OP_LOD, 4'd5, 4'd0, 4'd9, 1);
    check("lod5_after_rst", 32'(k_ready), 32'd0);

    // Unlisted op: no reads, no write
    run_txn(4'hF, 4'd9, 4'd9, 4'd10, 1);
    check("unlisted_latency", 32'(k_ready), 32'd0);
    check("unlisted_opnd_a", 32'(opnd_a), 32'h00);
    check("unlisted_opnd_b", 32'(opnd_b), 32'h00);
    run_txn(OP_ADDI, 4'd10, 4'd0, 4'd11, 0);
    check("unlisted_no_set", 32'(k_ready), 32'd0);
    sched_k = 1; sched_a = 4'd9; sched_v = 8'h99;
    run_txn(OP_ADDI, 4'd9, 4'd0, 4'd12, 0);
    sched_k = -1;
    check("unlisted_no_clear", 32'(stalled_at_accept), 32'd1);

    // Randomized transactions
    wb_pct = 30;
    for (int n = 0; n < 250; n++) begin
      r_op = ($urandom_range(7) == 0) ? 4'($urandom) : 4'($urandom_range(6, 1));
      abort_k = ($urandom_range(5) == 0) ? int'($urandom_range(3, 1)) : -1;
      rst_k   = ($urandom_range(30) == 0) ? int'($urandom_range(3, 1)) : -1;
      run_txn(r_op, 4'($urandom), ($urandom_range(4) == 0) ? src_a : 4'($urandom),
              4'($urandom), int'($urandom_range(2)));
    end
    abort_k = -1;
    rst_k   = -1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
